// File: rtl/hs32_execute2_pkg.sv
// hs32_execute2_pkg: stage-1/stage-2 packet types, opcodes, NZCV bit indices and multiplier FSM states
package hs32_execute2_pkg;
    typedef enum logic [3:0] {
        HS32_ALU_ADD,
        HS32_ALU_SUB,
        HS32_ALU_AND,
        HS32_ALU_OR,
        HS32_ALU_XOR,
        HS32_ALU_MOV,
        HS32_ALU_CMP,
        HS32_ALU_MUL
    } hs32_opc_e;

    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [31:0] d2;
        logic [4:0]  shl;
        logic [4:0]  shr;
        logic        sext;
        logic        maskl;
        logic        maskr;
        logic [3:0]  opc;
    } hs32_s1pkt;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] res;
        logic        we;
        logic        ud;
    } hs32_s2pkt;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} hs32_mul_state_e;
endpackage

// File: rtl/hs32_execute2_if.sv
// hs32_execute2_if: decode, regfile-read, writeback and hazard signals around the execute stage
interface hs32_execute2_if;
    import hs32_execute2_pkg::*;
    logic [3:0]  rp_addr;
    logic [31:0] rp_data;
    logic        in_valid;
    logic        in_ready;
    hs32_s1pkt   in_data;
    logic        out_valid;
    logic        out_ready;
    hs32_s2pkt   out_data;
    logic [3:0]  flags;
    logic [3:0]  rd2;
    logic        stl2;
    modport master (
        input  rp_addr, in_ready, out_valid, out_data, flags, rd2, stl2,
        output rp_data, in_valid, in_data, out_ready
    );
    modport slave (
        output rp_addr, in_ready, out_valid, out_data, flags, rd2, stl2,
        input  rp_data, in_valid, in_data, out_ready
    );
endinterface

// File: rtl/hs32_execute2_shifter.sv
// hs32_execute2_shifter: combinational funnel shifter producing operand B from d2
module hs32_execute2_shifter (
    input  logic [31:0] d2,
    input  logic [4:0]  shl,
    input  logic [4:0]  shr,
    input  logic        sext,
    input  logic        maskl,
    input  logic        maskr,
    output logic [31:0] sh
);
    logic [31:0] l, r, asr;
    assign l = d2 << shl;
    // kept apart from the mux so the arithmetic shift stays signed
    assign asr = $signed(d2) >>> shr;
    assign r = sext ? asr : d2 >> shr;
    assign sh = (maskr ? r : l) | (maskl ? 32'd0 : l);
endmodule

// File: rtl/hs32_execute2.sv
// hs32_execute2: stage-2 execute unit (shift, ALU, NZCV, hazard export); define HS32_MUL_EN for the iterative multiplier
module hs32_execute2 import hs32_execute2_pkg::*; #(
    parameter int MUL_STEP_BITS = 2
) (
    input logic clk,
    input logic reset_n,
    hs32_execute2_if.slave bus
);
`ifdef HS32_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_CYCLES = 32 / MUL_STEP_BITS;

    hs32_s1pkt p;
    hs32_s2pkt out_data, alu_pkt;
    hs32_mul_state_e state, state_nx;
    logic out_valid, in_ready, accept, handoff, start_mul, mul_last, busy;
    logic is_arith, is_logic, is_mul, is_cmp, v;
    logic [3:0] flags, flags_nx;
    logic [31:0] a, b, lr, mcand, mplier, acc, acc_nx;
    logic [32:0] r;
    logic [5:0] cnt;

    assign p = bus.in_data;
    assign a = bus.rp_data;
    assign bus.rp_addr = p.rm;

    hs32_execute2_shifter u_shifter (
        .d2(p.d2), .shl(p.shl), .shr(p.shr), .sext(p.sext), .maskl(p.maskl), .maskr(p.maskr), .sh(b)
    );

    assign is_cmp = p.opc == HS32_ALU_CMP;
    assign is_arith = p.opc == HS32_ALU_ADD || p.opc == HS32_ALU_SUB || is_cmp;
    assign is_logic = p.opc inside {HS32_ALU_AND, HS32_ALU_OR, HS32_ALU_XOR, HS32_ALU_MOV};
    assign is_mul = MUL_EN && p.opc == HS32_ALU_MUL;

    assign lr = p.opc == HS32_ALU_AND ? a & b : p.opc == HS32_ALU_OR ? a | b : p.opc == HS32_ALU_XOR ? a ^ b : b;
    // subtract as A + ~B + 1 so bit 32 is the no-borrow carry
    assign r = p.opc == HS32_ALU_ADD ? {1'b0, a} + {1'b0, b} : is_arith ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, lr};
    assign v = (a[31] ^ r[31]) & (p.opc == HS32_ALU_ADD ? ~(a[31] ^ b[31]) : a[31] ^ b[31]);
    assign flags_nx = is_arith ? {r[31], r[31:0] == 32'd0, r[32], v} : is_logic ? {r[31], r[31:0] == 32'd0, flags[1:0]} : flags;
    assign alu_pkt = '{
        rd:  p.rd,
        res: is_arith || is_logic ? r[31:0] : 32'd0,
        we:  !is_cmp && (is_arith || is_logic || is_mul),
        ud:  !(is_arith || is_logic || is_mul)
    };

    assign accept = bus.in_valid && in_ready;
    assign handoff = out_valid && bus.out_ready;
    assign start_mul = accept && is_mul;
    assign mul_last = cnt == 6'(MUL_CYCLES - 1);
    assign acc_nx = acc + mcand * 32'(mplier[MUL_STEP_BITS-1:0]);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == IDLE && start_mul) state_nx = BUSY;
        if (state == BUSY && mul_last) state_nx = DONE;
        if (state == DONE && handoff) state_nx = IDLE;
    end

    always_comb begin
        in_ready = state == IDLE && (!out_valid || bus.out_ready);
        busy = state == BUSY;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data <= '0;
            flags <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
        end else if (accept) begin
            out_valid <= !is_mul;
            out_data <= alu_pkt;
            flags <= flags_nx;
            acc <= '0;
            mcand <= a;
            mplier <= b;
            cnt <= '0;
        end else if (busy) begin
            acc <= acc_nx;
            mcand <= mcand << MUL_STEP_BITS;
            mplier <= mplier >> MUL_STEP_BITS;
            cnt <= cnt + 6'd1;
            if (mul_last) begin
                out_valid <= 1'b1;
                out_data.res <= acc_nx;
                flags[FLAG_N] <= acc_nx[31];
                flags[FLAG_Z] <= acc_nx == 32'd0;
            end
        end else if (handoff) begin
            out_valid <= 1'b0;
            out_data <= '0;
        end

    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data = out_data;
    assign bus.flags = flags;
    assign bus.rd2 = out_data.rd;
    // a multiply in flight already owns its rd
    assign bus.stl2 = (out_valid && out_data.we) || busy;
endmodule

// File: tb/tb_hs32_execute2.sv
// tb_hs32_execute2: directed literal checks plus randomized traffic against a behavioural model of the execute stage
module tb_hs32_execute2;
    import hs32_execute2_pkg::*;

    localparam int MUL_CYCLES = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    hs32_execute2_if bus();
    hs32_execute2 dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [31:0] rf [16];
    assign bus.rp_data = rf[bus.rp_addr];

    int checks = 0;
    int passed = 0;

    bit          m_valid, m_mdone;
    int          m_busy;
    hs32_s2pkt   m_pkt;
    logic [3:0]  m_flags;
    logic [31:0] m_prod;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_shift(input hs32_s1pkt p);
        logic [31:0] l, r;
        int s;
        l = p.d2 << p.shl;
        s = p.d2;
        if (p.sext) r = s >>> p.shr;
        else r = p.d2 >> p.shr;
        return (p.maskr ? r : l) | (p.maskl ? 32'd0 : l);
    endfunction

    task automatic ref_exec(input hs32_s1pkt p, input logic [31:0] a, inout logic [3:0] f,
                            output hs32_s2pkt o, output bit mul, output logic [31:0] prod);
        logic [31:0] b, r;
        longint s;
        bit c, v, ar, lg;
        b = ref_shift(p);
        prod = a * b;
        mul = 0; ar = 0; lg = 0; r = 0; c = 0; s = 0;
        case (p.opc)
            HS32_ALU_ADD: begin
                r = a + b; ar = 1;
                c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                s = longint'(int'(a)) + longint'(int'(b));
            end
            HS32_ALU_SUB, HS32_ALU_CMP: begin
                r = a - b; ar = 1;
                c = a >= b;
                s = longint'(int'(a)) - longint'(int'(b));
            end
            HS32_ALU_AND: begin r = a & b; lg = 1; end
            HS32_ALU_OR:  begin r = a | b; lg = 1; end
            HS32_ALU_XOR: begin r = a ^ b; lg = 1; end
            HS32_ALU_MOV: begin r = b; lg = 1; end
`ifdef HS32_MUL_EN
            HS32_ALU_MUL: mul = 1;
`endif
            default: ;
        endcase
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
        o.rd = p.rd;
        o.res = (ar || lg) ? r : 32'd0;
        o.we = (ar && p.opc != HS32_ALU_CMP) || lg || mul;
        o.ud = !(ar || lg || mul);
        if (ar) f = {r[31], r == 32'd0, c, v};
        else if (lg) begin
            f[3] = r[31];
            f[2] = r == 32'd0;
        end
    endtask

    // model compare and advance: inputs are stable here and are the ones the next rising edge sees
    always @(negedge clk) begin
        bit er, hand, take, mul;
        hs32_s2pkt np;
        logic [31:0] prod;
        if (!reset_n) begin
            m_valid = 0; m_mdone = 0; m_busy = 0; m_pkt = '0; m_flags = '0;
        end
        er = m_busy == 0 && !m_mdone && (!m_valid || bus.out_ready);
        chk("in_ready", 64'(bus.in_ready), 64'(er));
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (m_valid) chk("out_data", 64'(bus.out_data), 64'(m_pkt));
        chk("flags", 64'(bus.flags), 64'(m_flags));
        chk("stl2", 64'(bus.stl2), 64'((m_valid && m_pkt.we) || m_busy > 0));
        chk("rd2", 64'(bus.rd2), 64'(m_pkt.rd));
        chk("rp_addr", 64'(bus.rp_addr), 64'(bus.in_data.rm));
        if (reset_n) begin
            hand = m_valid && bus.out_ready;
            take = bus.in_valid && er;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1; m_mdone = 1; m_pkt.res = m_prod;
                    m_flags[3] = m_prod[31];
                    m_flags[2] = m_prod == 32'd0;
                end
            end else if (take) begin
                ref_exec(bus.in_data, rf[bus.in_data.rm], m_flags, np, mul, prod);
                m_pkt = np; m_valid = !mul; m_mdone = 0; m_prod = prod;
                m_busy = mul ? MUL_CYCLES : 0;
            end else if (hand) begin
                m_valid = 0; m_mdone = 0; m_pkt = '0;
            end
        end
    end

    function automatic hs32_s1pkt mk(input logic [3:0] opc, input logic [3:0] rd, input logic [3:0] rm,
                                     input logic [31:0] d2, input logic [4:0] shl, input logic [4:0] shr,
                                     input logic sext, input logic maskl, input logic maskr);
        hs32_s1pkt p;
        p.rd = rd; p.rm = rm; p.d2 = d2; p.shl = shl; p.shr = shr;
        p.sext = sext; p.maskl = maskl; p.maskr = maskr; p.opc = opc;
        return p;
    endfunction

    function automatic hs32_s1pkt rnd_pkt();
        hs32_s1pkt p;
        p.rd = 4'($urandom); p.rm = 4'($urandom); p.d2 = $urandom;
        p.shl = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
        p.shr = 5'($urandom);
        p.sext = 1'($urandom); p.maskl = 1'($urandom); p.maskr = 1'($urandom);
        p.opc = ($urandom % 8 == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
        return p;
    endfunction

    task automatic send(input hs32_s1pkt p);
        bus.in_data = p;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_data = '0;
        foreach (rf[i]) rf[i] = $urandom;
        #1 reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
        chk("reset_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_flags", 64'(bus.flags), 64'd0);
        chk("reset_stl2", 64'(bus.stl2), 64'd0);
        chk("reset_data", 64'(bus.out_data), 64'd0);

        rf[1] = 32'd0;
        send(mk(HS32_ALU_ADD, 4'd2, 4'd1, 32'h8000_0001, 5'd4, 5'd28, 1'b0, 1'b0, 1'b1));
        chk("rot_valid", 64'(bus.out_valid), 64'd1);
        chk("rot_res", 64'(bus.out_data.res), 64'h18);

        send(mk(HS32_ALU_MOV, 4'd4, 4'd3, 32'hF000_0000, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1));
        chk("asr_res", 64'(bus.out_data.res), 64'hFF00_0000);
        chk("asr_n", 64'(bus.flags[FLAG_N]), 64'd1);

        rf[5] = 32'd5;
        send(mk(HS32_ALU_SUB, 4'd6, 4'd5, 32'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        chk("sub_res", 64'(bus.out_data.res), 64'd0);
        chk("sub_flags", 64'(bus.flags), 64'b0110);
        chk("sub_stl2", 64'(bus.stl2), 64'd1);
        send(mk(HS32_ALU_CMP, 4'd6, 4'd5, 32'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        chk("cmp_valid", 64'(bus.out_valid), 64'd1);
        chk("cmp_we", 64'(bus.out_data.we), 64'd0);
        chk("cmp_stl2", 64'(bus.stl2), 64'd0);
        chk("cmp_flags", 64'(bus.flags), 64'b0110);

        rf[9] = 32'd100;
        send(mk(HS32_ALU_ADD, 4'd7, 4'd9, 32'd23, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        bus.out_ready = 1'b0;
        bus.in_data = mk(HS32_ALU_ADD, 4'd8, 4'd9, 32'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("bp_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_res", 64'(bus.out_data.res), 64'd123);
            chk("bp_stl2", 64'(bus.stl2), 64'd1);
            chk("bp_rd2", 64'(bus.rd2), 64'd7);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1 chk("rel_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rel_rd", 64'(bus.out_data.rd), 64'd8);
        chk("rel_res", 64'(bus.out_data.res), 64'd101);
        @(posedge clk); #1;
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_stl2", 64'(bus.stl2), 64'd0);
        chk("drain_rd2", 64'(bus.rd2), 64'd0);

        bus.out_ready = 1'b0;
        send(mk(HS32_ALU_SUB, 4'd3, 4'd1, 32'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_flags", 64'(bus.flags), 64'd0);
        chk("rst_stl2", 64'(bus.stl2), 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        bus.out_ready = 1'b1;
        send(mk(HS32_ALU_ADD, 4'd2, 4'd1, 32'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        chk("post_rst_res", 64'(bus.out_data.res), 64'd7);

        rf[10] = 32'h1234;
`ifdef HS32_MUL_EN
        send(mk(HS32_ALU_MUL, 4'd11, 4'd10, 32'h10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < MUL_CYCLES; i++) begin
            chk("mul_stl2", 64'(bus.stl2), 64'd1);
            chk("mul_busy_valid", 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
        end
        chk("mul_valid", 64'(bus.out_valid), 64'd1);
        chk("mul_res", 64'(bus.out_data.res), 64'h12340);
        chk("mul_ud", 64'(bus.out_data.ud), 64'd0);
        @(posedge clk); #1;
        send(mk(HS32_ALU_MUL, 4'd11, 4'd10, 32'h10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mrst_stl2", 64'(bus.stl2), 64'd0);
        chk("mrst_rd2", 64'(bus.rd2), 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        #1 chk("mrst_ready", 64'(bus.in_ready), 64'd1);
        send(mk(HS32_ALU_ADD, 4'd2, 4'd10, 32'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        chk("mrst_next", 64'(bus.out_data.res), 64'h1235);
`else
        send(mk(HS32_ALU_MUL, 4'd11, 4'd10, 32'h10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        chk("mul_valid", 64'(bus.out_valid), 64'd1);
        chk("mul_ud", 64'(bus.out_data.ud), 64'd1);
        chk("mul_we", 64'(bus.out_data.we), 64'd0);
`endif
        @(posedge clk); #1;

        for (int k = 0; k < 3000; k++) begin
            bus.in_data = rnd_pkt();
            bus.in_valid = $urandom % 4 != 0;
            bus.out_ready = $urandom % 4 != 0;
            if ($urandom % 8 == 0) rf[$urandom % 16] = $urandom;
            if (k == 1500) reset_n = 1'b0;
            if (k == 1503) reset_n = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (MUL_CYCLES + 4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
